rect_fill_engine: RTL and testbench
===================================

// Module: rect_fill_engine
// PURPOSE
//   Rasterises axis-aligned filled rectangles into a stream of single-pixel
//   writes (x, y, colour, plot) that drives vga_adapter directly. It sits
//   upstream of the adapter and downstream of the game FSM.
//   The FSM issues one command per paddle, ball, background or centre line
//   instead of running its own per-pixel counters.
// PARAMETERS
//   X_W       8    width of x coordinate / rectangle width
//   Y_W       8    width of y coordinate / rectangle height
//   COLOUR_W  3    colour bits (1 bit per channel)
//   SCREEN_W  160  visible columns; pixels at x >= SCREEN_W are clipped
//   SCREEN_H  120  visible rows; pixels at y >= SCREEN_H are clipped
// PORTS
//   clk         in   1         system clock (same clock as vga_adapter)
//   rst         in   1         synchronous reset, active-high
//   cmd_valid   in   1         command present
//   cmd_ready   out  1         engine can accept a command (IDLE and not rst)
//   cmd_x       in   X_W       left column
//   cmd_y       in   Y_W       top row
//   cmd_w       in   X_W       width in pixels (0 = empty)
//   cmd_h       in   Y_W       height in pixels (0 = empty)
//   cmd_colour  in   COLOUR_W  fill colour
//   abort       in   1         drop the current command
//   x           out  X_W       pixel column to adapter (registered)
//   y           out  Y_W       pixel row to adapter (registered)
//   colour      out  COLOUR_W  pixel colour to adapter (registered)
//   plot        out  1         write enable to adapter (registered)
//   busy        out  1         high while in FILL
//   done        out  1         one-cycle pulse when a command completes
// BEHAVIOUR
//   Reset: state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; cmd_ready=0 while rst=1.
//   FSM: IDLE -(cmd_valid&cmd_ready, w!=0, h!=0)-> FILL; FILL -(last slot or abort)-> IDLE.
//   Accept at edge N: latch the command and clear col/row counters.
//   First pixel slot is on the outputs at N+1.
//   Raster order is row-major, x inner. One slot per cycle; col and row are unsigned counters.
//   Slot: x = cmd_x+col, y = cmd_y+row, computed at X_W+1 / Y_W+1 bits.
//   plot=1 only if the sum is below SCREEN_W/SCREEN_H and has not carried.
//   Clipped slots still consume their cycle: w*h slots total, exactly.
//   done pulses at N+w*h+1, the cycle after the last slot. plot=0 that cycle; cmd_ready=1.
//   Back-to-back: a command accepted in the done cycle has its first slot the next cycle.
//   Empty command (w==0 or h==0): accepted, no slot issued, plot stays 0.
//     done pulses at N+1 and the state remains IDLE.
//   abort in FILL: the slot on the outputs that cycle is the last one.
//     Next cycle: IDLE, plot=0, done=0.
//   abort in IDLE is ignored. abort in the same cycle as acceptance: abort wins
//     (cmd consumed, no slots, no done).
//   rst mid-FILL: immediate return to the reset values. The partial rectangle is not resumed.
//   Outside slot cycles plot=0 and x/y/colour hold their last values.
//   Command inputs are sampled only at acceptance.
// CONFIGURATION
//   RECT_FILL_STRIDE_EN defined: adds the input cmd_ystep [Y_W-1:0].
//     Only rows y, y+s, y+2s ... below cmd_y+cmd_h are drawn; s=0 is treated as 1.
//     Skipped rows consume no cycles.
//     Slot count = w*ceil(h/s); done timing follows that count.
//     Used for the dashed centre line (w=1, h=120, s=3 -> 40 slots).
//   Not defined: no cmd_ystep port; the stride is fixed at 1.
// STRUCTURE
//   pong_gfx_pkg holds SCREEN_W/SCREEN_H and the colour constants:
//     COL_BLACK=3'b000, COL_WHITE=3'b111, COL_RED=3'b100, COL_GREEN=3'b010, COL_YELLOW=3'b110.
//   pong_gfx_pkg also holds the rect_cmd_t typedef {x,y,w,h,colour} and the state enum.
//   Sub-module raster_counter: col/row counters with the last-slot flag and the
//     stride step. The engine adds the offset, clip and output registers.
// TESTING
//   1. cmd (10,52,1,16,COL_WHITE) -> 16 slots, x=10, y=52..67, plot=1 each; done at N+17.
//   2. cmd (158,118,4,4) -> 16 slots; plot=1 only for x<=159 & y<=119 (4 pixels); done at N+17.
//   3. cmd w=0 -> no plot, done at N+1; a second cmd in the done cycle starts at the next cycle.
//   4. abort at slot 5 of (0,0,8,8) -> plot=0 from slot 6 on, no done, cmd_ready=1.
//   5. rst at slot 3 of (20,20,4,4) -> next cycle plot=0, x=0, y=0, busy=0, done=0.
//   6. [RECT_FILL_STRIDE_EN] (80,0,1,120,s=3) -> 40 slots, y=0,3,...,117; done at N+41.

Source files
------------

// File: rtl/pong_gfx_pkg.sv
// Shared graphics types and constants for the pong display path: screen size,
// colour palette, rectangle command record and fill-engine state encoding.
package pong_gfx_pkg;

    localparam int GFX_X_W      = 8;
    localparam int GFX_Y_W      = 8;
    localparam int GFX_COLOUR_W = 3;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [GFX_COLOUR_W-1:0] COL_BLACK  = 3'b000;
    localparam logic [GFX_COLOUR_W-1:0] COL_WHITE  = 3'b111;
    localparam logic [GFX_COLOUR_W-1:0] COL_RED    = 3'b100;
    localparam logic [GFX_COLOUR_W-1:0] COL_GREEN  = 3'b010;
    localparam logic [GFX_COLOUR_W-1:0] COL_YELLOW = 3'b110;

    typedef struct packed {
        logic [GFX_X_W-1:0]      x;
        logic [GFX_Y_W-1:0]      y;
        logic [GFX_X_W-1:0]      w;
        logic [GFX_Y_W-1:0]      h;
        logic [GFX_COLOUR_W-1:0] colour;
    } rect_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row slot counters for the rectangle rasteriser: row-major walk,
// x inner, with a programmable row step (0 treated as 1) and a last-slot flag.
module raster_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  logic           step_i,
    input  logic [X_W-1:0] w_i,
    input  logic [Y_W-1:0] h_i,
    input  logic [Y_W-1:0] ystep_i,
    output logic [X_W-1:0] col_o,
    output logic [Y_W-1:0] row_o,
    output logic           last_o
);

    logic [X_W-1:0] col_q, col_d;
    logic [Y_W-1:0] row_q, row_d;
    logic [Y_W-1:0] step_eff;
    logic [Y_W:0]   row_next;
    logic           col_end;
    logic           row_end;

    assign step_eff = (ystep_i == '0) ? Y_W'(1) : ystep_i;
    // One extra bit so row + step never wraps before the compare against h.
    assign row_next = {1'b0, row_q} + {1'b0, step_eff};
    assign col_end  = (col_q == w_i - X_W'(1));
    assign row_end  = (row_next >= {1'b0, h_i});
    assign last_o   = col_end && row_end;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (step_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_next[Y_W-1:0];
            end else begin
                col_d = col_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/rect_fill_engine.sv
// Rasterises filled axis-aligned rectangles into single-pixel writes for vga_adapter.
// Optional row stride (cmd_ystep input) is enabled by defining RECT_FILL_STRIDE_EN.
module rect_fill_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = pong_gfx_pkg::SCREEN_W,
    parameter int SCREEN_H = pong_gfx_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [X_W-1:0]      cmd_x,
    input  logic [Y_W-1:0]      cmd_y,
    input  logic [X_W-1:0]      cmd_w,
    input  logic [Y_W-1:0]      cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
`ifdef RECT_FILL_STRIDE_EN
    input  logic [Y_W-1:0]      cmd_ystep,
`endif
    input  logic                abort,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    import pong_gfx_pkg::*;

    fill_state_t state_q, state_d;
    rect_cmd_t   cmd_q;

    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;
    logic                last_out_q, last_out_d;
    logic                empty_pend_q, empty_pend_d;

    logic           accept, start, empty_cmd, issue, cnt_last, on_screen;
    logic [X_W-1:0] col;
    logic [Y_W-1:0] row;
    logic [Y_W-1:0] ystep;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;

    assign accept    = cmd_valid && cmd_ready;
    assign start     = accept && !abort && (cmd_w != '0) && (cmd_h != '0);
    assign empty_cmd = accept && !abort && ((cmd_w == '0) || (cmd_h == '0));
    // last_out_q marks the tail cycle: the final slot is already on the outputs.
    assign issue     = (state_q == ST_FILL) && !last_out_q && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)                 state_d = ST_FILL;
            ST_FILL: if (abort || last_out_q)   state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == ST_IDLE) && !rst;
        busy         = (state_q == ST_FILL);
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        last_out_d   = issue && cnt_last;
        empty_pend_d = empty_cmd;
        done_d       = ((state_q == ST_FILL) && last_out_q && !abort) || empty_pend_q;
        if (issue) begin
            x_d      = sum_x[X_W-1:0];
            y_d      = sum_y[Y_W-1:0];
            colour_d = cmd_q.colour;
            plot_d   = on_screen;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            cmd_q.x      <= cmd_x;
            cmd_q.y      <= cmd_y;
            cmd_q.w      <= cmd_w;
            cmd_q.h      <= cmd_h;
            cmd_q.colour <= cmd_colour;
        end
    end

`ifdef RECT_FILL_STRIDE_EN
    logic [Y_W-1:0] ystep_q;

    always_ff @(posedge clk) begin
        if (start) begin
            ystep_q <= cmd_ystep;
        end
    end

    assign ystep = ystep_q;
`else
    assign ystep = Y_W'(1);
`endif

    raster_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (start),
        .step_i  (issue),
        .w_i     (cmd_q.w),
        .h_i     (cmd_q.h),
        .ystep_i (ystep),
        .col_o   (col),
        .row_o   (row),
        .last_o  (cnt_last)
    );

    // Sums carry into the extra bit, so a wrapped coordinate is always clipped.
    assign sum_x     = {1'b0, cmd_q.x} + {1'b0, col};
    assign sum_y     = {1'b0, cmd_q.y} + {1'b0, row};
    assign on_screen = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
            last_out_q   <= 1'b0;
            empty_pend_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
            last_out_q   <= last_out_d;
            empty_pend_q <= empty_pend_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: reset, fills, clipping, empty and
// back-to-back commands, abort, mid-fill reset and (with RECT_FILL_STRIDE_EN) row stride.
module tb_rect_fill_engine;

    import pong_gfx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [2:0] cmd_colour;
`ifdef RECT_FILL_STRIDE_EN
    logic [7:0] cmd_ystep;
`endif
    logic       abort;
    logic [7:0] x, y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    rect_fill_engine dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
`ifdef RECT_FILL_STRIDE_EN
        .cmd_ystep  (cmd_ystep),
`endif
        .abort      (abort),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge, then scramble the command inputs.
    task automatic send_cmd(input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] cw,
                            input logic [7:0] ch, input logic [2:0] cc, input logic ab);
        cmd_x      = cx;
        cmd_y      = cy;
        cmd_w      = cw;
        cmd_h      = ch;
        cmd_colour = cc;
        cmd_valid  = 1'b1;
        abort      = ab;
        #1;
        chk("send.ready", cmd_ready, 1);
        tick();
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_x      = 8'hAA;
        cmd_y      = 8'h55;
        cmd_w      = 8'h03;
        cmd_h      = 8'h03;
        cmd_colour = 3'b101;
        chk("send.plot", plot, 0);
        chk("send.done", done, 0);
    endtask

    // Walk every slot after acceptance, then check the done cycle.
    task automatic expect_rect(input string tag, input int rx, input int ry, input int rw,
                               input int rh, input int rs, input logic [2:0] rc, input int exp_plots);
        int   nplot;
        int   rows;
        int   ex, ey;
        logic eplot;
        nplot = 0;
        rows  = (rh + rs - 1) / rs;
        for (int k = 0; k < rw * rows; k++) begin
            tick();
            ex    = rx + (k % rw);
            ey    = ry + (k / rw) * rs;
            eplot = (ex < 160) && (ey < 120);
            chk({tag, ".plot"}, plot, eplot);
            chk({tag, ".done_early"}, done, 0);
            if (eplot) begin
                chk({tag, ".x"}, x, ex);
                chk({tag, ".y"}, y, ey);
                chk({tag, ".colour"}, colour, rc);
                nplot++;
            end
        end
        tick();
        chk({tag, ".done"}, done, 1);
        chk({tag, ".done_plot"}, plot, 0);
        chk({tag, ".done_ready"}, cmd_ready, 1);
        chk({tag, ".done_busy"}, busy, 0);
        chk({tag, ".nplot"}, nplot, exp_plots);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_x      = '0;
        cmd_y      = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_colour = '0;
`ifdef RECT_FILL_STRIDE_EN
        cmd_ystep  = 8'd1;
`endif
        tick();
        tick();
        chk("rst.x", x, 0);
        chk("rst.y", y, 0);
        chk("rst.colour", colour, 0);
        chk("rst.plot", plot, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle.ready", cmd_ready, 1);

        // Vertical paddle: 16 slots, done 17 cycles after acceptance.
        send_cmd(8'd10, 8'd52, 8'd1, 8'd16, COL_WHITE, 1'b0);
        chk("t1.busy", busy, 1);
        expect_rect("t1", 10, 52, 1, 16, 1, COL_WHITE, 16);
        tick();
        chk("t1.done_pulse", done, 0);
        chk("t1.hold_x", x, 10);
        chk("t1.hold_y", y, 67);
        chk("t1.hold_colour", colour, COL_WHITE);

        // Corner clip: only 158..159 x 118..119 visible.
        send_cmd(8'd158, 8'd118, 8'd4, 8'd4, COL_YELLOW, 1'b0);
        expect_rect("t2", 158, 118, 4, 4, 1, COL_YELLOW, 4);
        tick();

        // Coordinate carry past 255 must be clipped, not wrapped.
        send_cmd(8'd250, 8'd10, 8'd8, 8'd1, COL_RED, 1'b0);
        expect_rect("carry", 250, 10, 8, 1, 1, COL_RED, 0);
        tick();

        // Empty command, then a command accepted in its done cycle.
        send_cmd(8'd30, 8'd30, 8'd0, 8'd5, COL_RED, 1'b0);
        chk("t3.busy", busy, 0);
        tick();
        chk("t3.done", done, 1);
        chk("t3.plot", plot, 0);
        chk("t3.busy_done", busy, 0);
        send_cmd(8'd5, 8'd5, 8'd2, 8'd1, COL_WHITE, 1'b0);
        expect_rect("t3b", 5, 5, 2, 1, 1, COL_WHITE, 2);
        tick();

        // Abort together with acceptance: consumed, nothing drawn, no done.
        send_cmd(8'd40, 8'd40, 8'd2, 8'd2, COL_WHITE, 1'b1);
        chk("abacc.busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abacc.plot", plot, 0);
            chk("abacc.done", done, 0);
        end

        // Abort in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abidle.ready", cmd_ready, 1);
        chk("abidle.done", done, 0);

        // Abort while slot 5 is on the outputs.
        send_cmd(8'd0, 8'd0, 8'd8, 8'd8, COL_RED, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4.plot", plot, 1);
            chk("t4.x", x, k);
            chk("t4.y", y, 0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4.ab_plot", plot, 0);
        chk("t4.ab_done", done, 0);
        chk("t4.ab_busy", busy, 0);
        chk("t4.ab_ready", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4.after_plot", plot, 0);
            chk("t4.after_done", done, 0);
        end

        // Reset while slot 3 is on the outputs.
        send_cmd(8'd20, 8'd20, 8'd4, 8'd4, COL_GREEN, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5.plot", plot, 1);
            chk("t5.x", x, 20 + k);
        end
        rst = 1'b1;
        tick();
        chk("t5.plot_rst", plot, 0);
        chk("t5.x_rst", x, 0);
        chk("t5.y_rst", y, 0);
        chk("t5.colour_rst", colour, 0);
        chk("t5.busy_rst", busy, 0);
        chk("t5.done_rst", done, 0);
        chk("t5.ready_rst", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("t5.ready_after", cmd_ready, 1);
        tick();
        chk("t5.plot_after", plot, 0);
        chk("t5.busy_after", busy, 0);
        chk("t5.done_after", done, 0);

`ifdef RECT_FILL_STRIDE_EN
        // Dashed centre line: every third row, 40 slots.
        cmd_ystep = 8'd3;
        send_cmd(8'd80, 8'd0, 8'd1, 8'd120, COL_WHITE, 1'b0);
        cmd_ystep = 8'd1;
        expect_rect("t6", 80, 0, 1, 120, 3, COL_WHITE, 40);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
